// File: rtl/butterfly_imag_mac.sv
// rtl/butterfly_imag_mac.sv - imaginary part of b*w: Reb*Imw + Imb*Rew via two parallel shift-add multipliers
module butterfly_imag_mac #(
    parameter int n  = 8,
    parameter int OW = 2*n+1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [n-1:0]         REB,
    input  logic [n-1:0]         IMW,
    input  logic [n-1:0]         IMB,
    input  logic [n-1:0]         REW,
    input  logic                 nMUL3,
    input  logic                 nMUL4,
    output logic                 ready,
    output logic                 done,
    output logic signed [OW-1:0] im_out
);

    localparam int AW = 2*n;
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, MUL, SUM} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [n-1:0]          reb_q, reb_d, imw_q, imw_d, imb_q, imb_d, rew_q, rew_d;
    logic                  nmul3_q, nmul3_d, nmul4_q, nmul4_d;
    logic [AW-1:0]         acc3_q, acc3_d, acc4_q, acc4_d;
    logic signed [OW-1:0]  im_q, im_d;
    logic                  done_q, done_d;
    logic signed [OW-1:0]  p3, p4;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            reb_q   <= '0;
            imw_q   <= '0;
            imb_q   <= '0;
            rew_q   <= '0;
            nmul3_q <= 1'b0;
            nmul4_q <= 1'b0;
            acc3_q  <= '0;
            acc4_q  <= '0;
            im_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            reb_q   <= reb_d;
            imw_q   <= imw_d;
            imb_q   <= imb_d;
            rew_q   <= rew_d;
            nmul3_q <= nmul3_d;
            nmul4_q <= nmul4_d;
            acc3_q  <= acc3_d;
            acc4_q  <= acc4_d;
            im_q    <= im_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reb_d   = reb_q;
        imw_d   = imw_q;
        imb_d   = imb_q;
        rew_d   = rew_q;
        nmul3_d = nmul3_q;
        nmul4_d = nmul4_q;
        acc3_d  = acc3_q;
        acc4_d  = acc4_q;
        im_d    = im_q;
        done_d  = 1'b0;
        p3      = '0;
        p4      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    reb_d   = REB;
                    imw_d   = IMW;
                    imb_d   = IMB;
                    rew_d   = REW;
                    nmul3_d = nMUL3;
                    nmul4_d = nMUL4;
                    acc3_d  = '0;
                    acc4_d  = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc3_d = acc3_q + (imw_q[cnt_q] ? (AW'(reb_q) << cnt_q) : '0);
                acc4_d = acc4_q + (rew_q[cnt_q] ? (AW'(imb_q) << cnt_q) : '0);
                if (cnt_q == CW'(n-1)) begin
                    state_d = SUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SUM: begin
                // negating a zero magnitude gives zero, so no negative-zero case exists
                p3 = OW'(acc3_q);
                p4 = OW'(acc4_q);
                if (nmul3_q) p3 = -p3;
                if (nmul4_q) p4 = -p4;
                im_d    = p3 + p4;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign im_out = im_q;

endmodule
